// File: rtl/pic8259_pkg.sv
// pic8259_pkg: shared acknowledge-state codes, CALL opcode and ACK2 byte formatting
package pic8259_pkg;
  typedef enum logic [2:0] {
    CTL_READY = 3'b000,
    CTL_ACK1  = 3'b001,
    CTL_ACK2  = 3'b010,
    CTL_ACK3  = 3'b011
  } ctl_state_t;
  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  function automatic logic [7:0] ack2_byte(input logic mode_8086, input logic interval_4,
                                           input logic [10:0] addr, input logic [2:0] level);
    return mode_8086  ? {addr[10:6], level} :
           interval_4 ? {addr[2:0], level, 2'b00} :
                        {addr[2:1], level, 3'b000};
  endfunction
endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// interrupt_ack_sequencer_if: acknowledge-state, strobe and data-bus bundle shared with cascade logic
interface interrupt_ack_sequencer_if;
  import pic8259_pkg::*;
  ctl_state_t control_state;
  logic cascade_output_ack_2_3;
  logic latch_in_service;
  logic end_of_acknowledge_sequence;
  logic out_control_logic_data;
  logic [7:0] control_logic_data;
  modport master (
    output control_state, latch_in_service, end_of_acknowledge_sequence,
           out_control_logic_data, control_logic_data,
    input  cascade_output_ack_2_3
  );
  modport slave (
    input  control_state, latch_in_service, end_of_acknowledge_sequence,
           out_control_logic_data, control_logic_data,
    output cascade_output_ack_2_3
  );
endinterface

// File: rtl/interrupt_ack_sequencer_inta_edge_detect.sv
// inta_edge_detect: one-clock INTA# delay with fall/rise detection, suppressing a fall right after reset
module inta_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);
  logic inta_q, armed_q;
  // delay line; armed_q blocks a fall from an INTA# that was already low when reset released
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inta_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      inta_q  <= inta_n;
      armed_q <= 1'b1;
    end
  end
  assign fall = armed_q & inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;
endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: 8259A INTA# sequencer (ACK1/ACK2/ACK3), strobes and vector bytes; MCS80_MODE_EN enables 3-pulse MCS-80 mode
module interrupt_ack_sequencer
  import pic8259_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        initialization,
  input  logic        interrupt_acknowledge_n,
  input  logic        u8086_or_mcs80_config,
  input  logic        call_address_interval_4_or_8_config,
  input  logic [10:0] interrupt_vector_address,
  input  logic [2:0]  acknowledge_level,
  input  logic        cascade_slave,
  interrupt_ack_sequencer_if.master bus
);
  logic fall, rise;
  ctl_state_t state_q, state_d;
  logic en_q, en_d, lis_q, lis_d, eoa_q, eoa_d;
  logic [7:0] data_q, data_d;
  inta_edge_detect u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .inta_n  (interrupt_acknowledge_n),
    .fall    (fall),
    .rise    (rise)
  );
`ifdef MCS80_MODE_EN
  logic mode_q, mode_d, call_en;
  assign call_en = ~u8086_or_mcs80_config & ~cascade_slave;
`else
  logic unused_cfg;
  assign unused_cfg = ^{u8086_or_mcs80_config, call_address_interval_4_or_8_config,
                        cascade_slave, interrupt_vector_address[5:0]};
`endif
  // state, mode latch, data byte, drive enable and strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CTL_READY;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      lis_q   <= 1'b0;
      eoa_q   <= 1'b0;
`ifdef MCS80_MODE_EN
      mode_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      lis_q   <= lis_d;
      eoa_q   <= eoa_d;
`ifdef MCS80_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end
  // next state and registered outputs; initialization overrides every edge event
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    en_d    = en_q & ~rise;
    lis_d   = 1'b0;
    eoa_d   = 1'b0;
`ifdef MCS80_MODE_EN
    mode_d  = mode_q;
`endif
    if (initialization) begin
      state_d = CTL_READY;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        CTL_READY: if (fall) begin
          state_d = CTL_ACK1;
          lis_d   = 1'b1;
`ifdef MCS80_MODE_EN
          mode_d  = u8086_or_mcs80_config;
          en_d    = call_en;
          data_d  = call_en ? CALL_OPCODE : data_q;
`else
          en_d    = 1'b0;
`endif
        end
        CTL_ACK1: if (fall) begin
          state_d = CTL_ACK2;
          en_d    = bus.cascade_output_ack_2_3;
`ifdef MCS80_MODE_EN
          data_d  = ack2_byte(mode_q, call_address_interval_4_or_8_config,
                              interrupt_vector_address, acknowledge_level);
`else
          data_d  = {interrupt_vector_address[10:6], acknowledge_level};
`endif
        end
`ifdef MCS80_MODE_EN
        CTL_ACK2: if (mode_q && rise) begin
          state_d = CTL_READY;
          eoa_d   = 1'b1;
        end else if (!mode_q && fall) begin
          state_d = CTL_ACK3;
          en_d    = bus.cascade_output_ack_2_3;
          data_d  = interrupt_vector_address[10:3];
        end
        CTL_ACK3: if (rise) begin
          state_d = CTL_READY;
          eoa_d   = 1'b1;
        end
`else
        CTL_ACK2: if (rise) begin
          state_d = CTL_READY;
          eoa_d   = 1'b1;
        end
`endif
        default: state_d = CTL_READY;
      endcase
    end
  end
  assign bus.control_state               = state_q;
  assign bus.control_logic_data          = data_q;
  assign bus.out_control_logic_data      = en_q;
  assign bus.latch_in_service            = lis_q;
  assign bus.end_of_acknowledge_sequence = eoa_q;
endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// tb_interrupt_ack_sequencer: directed INTA# sequences with hand-computed expected states and bytes
module tb_interrupt_ack_sequencer;
  logic clock = 1'b0;
  logic reset_n, initialization, inta_n, mode, interval, slave;
  logic [10:0] addr;
  logic [2:0] level;
  int n_vec = 0;
  int n_err = 0;
  interrupt_ack_sequencer_if bus ();
  interrupt_ack_sequencer dut (
    .clock                               (clock),
    .reset_n                             (reset_n),
    .initialization                      (initialization),
    .interrupt_acknowledge_n             (inta_n),
    .u8086_or_mcs80_config               (mode),
    .call_address_interval_4_or_8_config (interval),
    .interrupt_vector_address            (addr),
    .acknowledge_level                   (level),
    .cascade_slave                       (slave),
    .bus                                 (bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [2:0] st, input logic en,
                            input logic lis, input logic eoa);
    chk({tag, ".state"}, 32'(bus.control_state), 32'(st));
    chk({tag, ".en"}, 32'(bus.out_control_logic_data), 32'(en));
    chk({tag, ".lis"}, 32'(bus.latch_in_service), 32'(lis));
    chk({tag, ".eoa"}, 32'(bus.end_of_acknowledge_sequence), 32'(eoa));
  endtask
  task automatic step(input logic v);
    inta_n = v;
    @(negedge clock);
  endtask
  initial begin
    logic en_seen;
    int lis_cnt, eoa_cnt;
    logic [4:0] pat;
    reset_n = 1'b0; initialization = 1'b0; inta_n = 1'b1; mode = 1'b1; interval = 1'b0;
    addr = 11'h200; level = 3'd3; slave = 1'b0; bus.cascade_output_ack_2_3 = 1'b1;
    repeat (2) @(negedge clock);
    expect_out("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.data", 32'(bus.control_logic_data), 32'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    // 8086, base 01000, level 3
    step(1'b0); expect_out("t1.ack1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1); expect_out("t1.r1", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0); expect_out("t1.ack2", 3'd2, 1'b1, 1'b0, 1'b0);
    chk("t1.data", 32'(bus.control_logic_data), 32'h43);
    step(1'b1); expect_out("t1.end", 3'd0, 1'b0, 1'b0, 1'b1);
    // back-to-back: MCS-80 request, interval 4, address 5A7, level 2
    mode = 1'b0; interval = 1'b1; addr = 11'h5A7; level = 3'd2;
`ifdef MCS80_MODE_EN
    step(1'b0); expect_out("t2.ack1", 3'd1, 1'b1, 1'b1, 1'b0);
    chk("t2.call", 32'(bus.control_logic_data), 32'hCD);
    step(1'b1); expect_out("t2.r1", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0); expect_out("t2.ack2", 3'd2, 1'b1, 1'b0, 1'b0);
    chk("t2.lo", 32'(bus.control_logic_data), 32'hE8);
    step(1'b1); expect_out("t2.r2", 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0); expect_out("t2.ack3", 3'd3, 1'b1, 1'b0, 1'b0);
    chk("t2.hi", 32'(bus.control_logic_data), 32'hB4);
    step(1'b1); expect_out("t2.end", 3'd0, 1'b0, 1'b0, 1'b1);
`else
    step(1'b0); expect_out("t2.ack1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1); expect_out("t2.r1", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0); expect_out("t2.ack2", 3'd2, 1'b1, 1'b0, 1'b0);
    chk("t2.vec", 32'(bus.control_logic_data), 32'hB2);
    step(1'b1); expect_out("t2.end", 3'd0, 1'b0, 1'b0, 1'b1);
`endif
    step(1'b1);
    // master not owning ACK2: never drives, strobes still once each
    mode = 1'b1; addr = 11'h200; level = 3'd3; bus.cascade_output_ack_2_3 = 1'b0;
    en_seen = 1'b0; lis_cnt = 0; eoa_cnt = 0; pat = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      step(pat[i]);
      en_seen |= bus.out_control_logic_data;
      lis_cnt += int'(bus.latch_in_service);
      eoa_cnt += int'(bus.end_of_acknowledge_sequence);
    end
    chk("t3.en_seen", 32'(en_seen), 32'd0);
    chk("t3.lis_cnt", 32'(lis_cnt), 32'd1);
    chk("t3.eoa_cnt", 32'(eoa_cnt), 32'd1);
    chk("t3.state", 32'(bus.control_state), 32'd0);
    chk("t3.data", 32'(bus.control_logic_data), 32'h43);
    // initialization in ACK2
    bus.cascade_output_ack_2_3 = 1'b1;
`ifdef MCS80_MODE_EN
    mode = 1'b0;
`endif
    step(1'b0); step(1'b1); step(1'b0);
    expect_out("t4.ack2", 3'd2, 1'b1, 1'b0, 1'b0);
    initialization = 1'b1;
    @(negedge clock);
    initialization = 1'b0;
    expect_out("t4.init", 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    chk("t4.idle.state", 32'(bus.control_state), 32'd0);
    chk("t4.idle.eoa", 32'(bus.end_of_acknowledge_sequence), 32'd0);
    step(1'b0);
    chk("t4.ack1.state", 32'(bus.control_state), 32'd1);
    chk("t4.ack1.lis", 32'(bus.latch_in_service), 32'd1);
    // async reset in ACK1 with INTA# held low
    mode = 1'b1;
    #2 reset_n = 1'b0;
    #1 expect_out("t5.rst", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("t5.data", 32'(bus.control_logic_data), 32'h00);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t5.hold.state", 32'(bus.control_state), 32'd0);
      chk("t5.hold.lis", 32'(bus.latch_in_service), 32'd0);
    end
    step(1'b1); chk("t5.high", 32'(bus.control_state), 32'd0);
    step(1'b0); expect_out("t5.ack1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1);
    step(1'b0); chk("t5.data2", 32'(bus.control_logic_data), 32'h43);
    step(1'b1); expect_out("t5.end", 3'd0, 1'b0, 1'b0, 1'b1);
    // mode change mid-sequence only affects the next sequence
    mode = 1'b0;
    step(1'b0); chk("t6.ack1", 32'(bus.control_state), 32'd1);
    mode = 1'b1;
    step(1'b1);
    step(1'b0); chk("t6.ack2", 32'(bus.control_state), 32'd2);
`ifdef MCS80_MODE_EN
    step(1'b1); expect_out("t6.r2", 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0); chk("t6.ack3", 32'(bus.control_state), 32'd3);
    step(1'b1); expect_out("t6.end", 3'd0, 1'b0, 1'b0, 1'b1);
`else
    step(1'b1); expect_out("t6.end", 3'd0, 1'b0, 1'b0, 1'b1);
`endif
    step(1'b0); chk("t6.n.ack1", 32'(bus.control_state), 32'd1);
    step(1'b1);
    step(1'b0); chk("t6.n.ack2", 32'(bus.control_state), 32'd2);
    step(1'b1); expect_out("t6.n.end", 3'd0, 1'b0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
